ppg_spo2_calc: RTL and testbench

//  Consumes the per-channel RED/IR ADC samples produced by the LED/PGA controller once its

---
 rtl/ppg_pkg.sv | 38 +++
 rtl/ppg_seq_divider.sv | 67 ++++++
 rtl/ppg_spo2_calc.sv | 197 +++++++++++++++++++
 tb/tb_ppg_spo2_calc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG SpO2 calculator: compute FSM states,
// mapping defaults, fixed-point widths and the ratio saturation helper.
package ppg_pkg;

  // Compute FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_MAP,
    ST_OUT,
    ST_ERR
  } ppg_state_t;

  // Default window length and linear SpO2 mapping coefficients
  localparam int WIN_LEN_DEF = 100;
  localparam int SPO2_A_DEF  = 110;
  localparam int SPO2_B_DEF  = 25;
  localparam int SPO2_MAX    = 100;

  // Fixed-point and datapath widths
  localparam int Q8_FRAC = 8;
  localparam int SAMP_W  = 8;
  localparam int PROD_W  = 16;
  localparam int DIV_W   = 24;
  localparam int DEN_W   = 16;
  localparam int MAP_W   = 22;

  // Clamp the 24-bit quotient into the unsigned Q8.8 ratio output
  function automatic logic [PROD_W-1:0] sat_q8(input logic [DIV_W-1:0] q);
    if (|q[DIV_W-1:PROD_W]) begin
      sat_q8 = {PROD_W{1'b1}};
    end else begin
      sat_q8 = q[PROD_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ppg_seq_divider.sv
// Unsigned 24/16 restoring divider producing one quotient bit per cycle.
// Operands are captured on start; done pulses in the 24th cycle after start,
// and the final quotient is readable from the following cycle onward.
module ppg_seq_divider
  import ppg_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DEN_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DIV_W-1:0] o_quotient
);

  localparam logic [4:0] CNT_INIT = 5'(DIV_W);

  logic [DIV_W-1:0] r_quo;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_div;
  logic [4:0]       r_cnt;
  logic             r_busy;

  logic [DEN_W:0]   w_shift;
  logic             w_ge;
  logic [DEN_W-1:0] w_diff;

  // Partial remainder with the next dividend bit shifted in; it is always
  // below 2*divisor, so a 17-bit compare decides the quotient bit.
  assign w_shift = {r_rem, r_quo[DIV_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[DEN_W-1:0] - r_div;

  // Load operands on start, then iterate one restoring step per cycle
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_INIT;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_shift[DEN_W-1:0];
      r_quo <= {r_quo[DIV_W-2:0], w_ge};
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == 5'd1) && !i_abort;
  assign o_quotient = r_quo;

endmodule

// File: rtl/ppg_spo2_calc.sv
// SpO2 estimator: per-window RED/IR max/min tracking, AC/DC extraction,
// ratio-of-ratios in Q8.8 via a sequential divider, and linear mapping to
// a clamped SpO2 percentage.
module ppg_spo2_calc
  import ppg_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int SPO2_A  = SPO2_A_DEF,
  parameter int SPO2_B  = SPO2_B_DEF
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              red_valid,
  input  logic [SAMP_W-1:0] red_sample,
  input  logic              ir_valid,
  input  logic [SAMP_W-1:0] ir_sample,
  output logic              spo2_valid,
  output logic [6:0]        spo2,
  output logic [15:0]       ratio_q8,
  output logic              spo2_err,
  output logic              overrun
);

  localparam logic [SAMP_W-1:0] WIN_CNT = SAMP_W'(WIN_LEN);

  // Channel index 0 = RED, 1 = IR
  logic [1:0]             w_valid;
  logic [1:0][SAMP_W-1:0] w_sample;
  logic [1:0]             w_full;
  logic [1:0][SAMP_W-1:0] w_ac;
  logic [1:0][SAMP_W-1:0] w_dc;
  logic                   w_close;

  assign w_valid  = {ir_valid, red_valid};
  assign w_sample = {ir_sample, red_sample};
  assign w_close  = enable && (&w_full);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [SAMP_W-1:0] r_max;
    logic [SAMP_W-1:0] r_min;
    logic [SAMP_W-1:0] r_cnt;

    // Track window extremes; a full channel waits for its partner to fill
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        r_max <= '0;
        r_min <= '1;
        r_cnt <= '0;
      end else if (!enable || w_close) begin
        r_max <= '0;
        r_min <= '1;
        r_cnt <= '0;
      end else if (w_valid[gi] && (r_cnt != WIN_CNT)) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_sample[gi] > r_max) begin
          r_max <= w_sample[gi];
        end
        if (w_sample[gi] < r_min) begin
          r_min <= w_sample[gi];
        end
      end
    end

    assign w_full[gi] = (r_cnt == WIN_CNT);
    assign w_ac[gi]   = r_max - r_min;
    assign w_dc[gi]   = SAMP_W'(({1'b0, r_max} + {1'b0, r_min}) >> 1);
  end

  // Compute-side state
  ppg_state_t             r_state;
  logic [1:0][SAMP_W-1:0] r_ac;
  logic [1:0][SAMP_W-1:0] r_dc;
  logic                   r_spo2_valid;
  logic [6:0]             r_spo2;
  logic [15:0]            r_ratio_q8;
  logic                   r_spo2_err;
  logic                   r_overrun;

  // Ratio-of-ratios operands: num = ACr*DCir, den = ACir*DCr
  logic [PROD_W-1:0] w_num;
  logic [PROD_W-1:0] w_den;
  logic [DIV_W-1:0]  w_dividend;

  assign w_num      = {8'd0, r_ac[0]} * {8'd0, r_dc[1]};
  assign w_den      = {8'd0, r_ac[1]} * {8'd0, r_dc[0]};
  assign w_dividend = DIV_W'(w_num) << Q8_FRAC;

  // Divider is launched from MULT so its 24 iterations fill the DIV state
  logic             w_div_start;
  logic             w_div_abort;
  logic             w_div_busy;
  logic             w_div_done;
  logic [DIV_W-1:0] w_div_quo;

  assign w_div_start = enable && (r_state == ST_MULT) && (w_den != '0) && !w_div_busy;
  assign w_div_abort = !enable;

  ppg_seq_divider u_div (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_abort    (w_div_abort),
    .i_dividend (w_dividend),
    .i_divisor  (w_den),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );

  // Linear map: spo2 = A - ((B * R) >> 8), evaluated signed then clamped
  logic [15:0]             w_ratio_sat;
  logic [MAP_W-1:0]        w_prod;
  logic [MAP_W-1:0]        w_scaled;
  logic signed [MAP_W-1:0] w_spo2_s;
  logic [6:0]              w_spo2_map;

  assign w_ratio_sat = sat_q8(w_div_quo);
  assign w_prod      = MAP_W'(SPO2_B) * {6'd0, w_ratio_sat};
  assign w_scaled    = w_prod >> Q8_FRAC;
  assign w_spo2_s    = $signed(MAP_W'(SPO2_A)) - $signed(w_scaled);

  // Clamp the mapped percentage into 0..100
  always_comb begin
    w_spo2_map = '0;
    if (w_spo2_s < 0) begin
      w_spo2_map = '0;
    end else if (w_spo2_s > $signed(MAP_W'(SPO2_MAX))) begin
      w_spo2_map = 7'(SPO2_MAX);
    end else begin
      w_spo2_map = w_spo2_s[6:0];
    end
  end

  // Compute FSM with registered result/strobe outputs and sticky overrun
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ac         <= '0;
      r_dc         <= '0;
      r_spo2_valid <= 1'b0;
      r_spo2       <= '0;
      r_ratio_q8   <= '0;
      r_spo2_err   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_spo2_valid <= 1'b0;
      r_spo2_err   <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_close) begin
              r_ac    <= w_ac;
              r_dc    <= w_dc;
              r_state <= ST_MULT;
            end
          end
          ST_MULT: begin
            if (w_den == '0) begin
              r_spo2_err <= 1'b1;
              r_state    <= ST_ERR;
            end else begin
              r_state <= ST_DIV;
            end
          end
          ST_DIV: begin
            if (w_div_done) begin
              r_state <= ST_MAP;
            end
          end
          ST_MAP: begin
            r_ratio_q8   <= w_ratio_sat;
            r_spo2       <= w_spo2_map;
            r_spo2_valid <= 1'b1;
            r_state      <= ST_OUT;
          end
          ST_OUT:  r_state <= ST_IDLE;
          ST_ERR:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
        // A window finishing while a result is still in flight is dropped
        if (w_close && (r_state != ST_IDLE)) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign spo2_valid = r_spo2_valid;
  assign spo2       = r_spo2;
  assign ratio_q8   = r_ratio_q8;
  assign spo2_err   = r_spo2_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ppg_spo2_calc.sv
// Directed bench for ppg_spo2_calc with a 4-sample window.
module tb_ppg_spo2_calc;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        red_valid = 1'b0;
  logic [7:0]  red_sample = 8'd0;
  logic        ir_valid = 1'b0;
  logic [7:0]  ir_sample = 8'd0;
  logic        spo2_valid;
  logic [6:0]  spo2;
  logic [15:0] ratio_q8;
  logic        spo2_err;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  ppg_spo2_calc #(.WIN_LEN(4), .SPO2_A(110), .SPO2_B(25)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .enable     (enable),
    .red_valid  (red_valid),
    .red_sample (red_sample),
    .ir_valid   (ir_valid),
    .ir_sample  (ir_sample),
    .spo2_valid (spo2_valid),
    .spo2       (spo2),
    .ratio_q8   (ratio_q8),
    .spo2_err   (spo2_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Four paired strobes; sample k is byte k of each packed word.
  // Returns positioned in the window-close cycle.
  task automatic feed_window(input logic [31:0] rv, input logic [31:0] iv);
    for (int k = 0; k < 4; k++) begin
      red_valid  = 1'b1;
      ir_valid   = 1'b1;
      red_sample = rv[8*k +: 8];
      ir_sample  = iv[8*k +: 8];
      step();
    end
    red_valid = 1'b0;
    ir_valid  = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic got_v, output logic got_e);
    lat   = 0;
    got_v = 1'b0;
    got_e = 1'b0;
    while (!got_v && !got_e && lat < 60) begin
      step();
      lat++;
      got_v = spo2_valid;
      got_e = spo2_err;
    end
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (spo2_valid || spo2_err) cnt++;
    end
  endtask

  localparam logic [31:0] T1_RED = {8'd110, 8'd120, 8'd140, 8'd100};
  localparam logic [31:0] T1_IR  = {8'd120, 8'd130, 8'd150, 8'd110};
  localparam logic [31:0] T2_RED = {8'd115, 8'd120, 8'd130, 8'd110};
  localparam logic [31:0] T2_IR  = {8'd110, 8'd120, 8'd140, 8'd100};
  localparam logic [31:0] T3_RED = {8'd150, 8'd150, 8'd200, 8'd100};
  localparam logic [31:0] T3_IR  = {8'd130, 8'd130, 8'd135, 8'd125};
  localparam logic [31:0] TS_RED = {8'd255, 8'd0, 8'd255, 8'd0};
  localparam logic [31:0] TS_IR  = {8'd201, 8'd200, 8'd201, 8'd200};
  localparam logic [31:0] T4_IR  = {8'd128, 8'd128, 8'd128, 8'd128};

  initial begin
    int   lat;
    int   cnt;
    logic v;
    logic e;

    // Reset state
    repeat (3) step();
    check("rst_spo2_valid", spo2_valid, 0);
    check("rst_spo2", spo2, 0);
    check("rst_ratio_q8", ratio_q8, 0);
    check("rst_spo2_err", spo2_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    step();

    // T1: basic window, latency from close
    feed_window(T1_RED, T1_IR);
    wait_result(lat, v, e);
    check("t1_valid_seen", v, 1);
    check("t1_latency", lat, 27);
    check("t1_ratio_q8", ratio_q8, 277);
    check("t1_spo2", spo2, 83);
    step();
    check("t1_valid_one_cycle", spo2_valid, 0);

    // T3: quotient 2218, spo2 clamped at 0
    feed_window(T3_RED, T3_IR);
    wait_result(lat, v, e);
    check("t3_valid_seen", v, 1);
    check("t3_ratio_q8", ratio_q8, 2218);
    check("t3_spo2", spo2, 0);

    // Saturation: quotient 102803 -> 0xFFFF
    feed_window(TS_RED, TS_IR);
    wait_result(lat, v, e);
    check("sat_valid_seen", v, 1);
    check("sat_ratio_q8", ratio_q8, 16'hFFFF);
    check("sat_spo2", spo2, 0);

    // T2: ratio 128, spo2 98
    feed_window(T2_RED, T2_IR);
    wait_result(lat, v, e);
    check("t2_valid_seen", v, 1);
    check("t2_latency", lat, 27);
    check("t2_ratio_q8", ratio_q8, 128);
    check("t2_spo2", spo2, 98);

    // T4: ACir = 0 -> error strobe at C+2, outputs hold
    feed_window(T1_RED, T4_IR);
    wait_result(lat, v, e);
    check("t4_err_seen", e, 1);
    check("t4_err_latency", lat, 2);
    check("t4_no_valid", v, 0);
    check("t4_spo2_hold", spo2, 98);
    check("t4_ratio_hold", ratio_q8, 128);
    step();
    check("t4_err_one_cycle", spo2_err, 0);
    count_strobes(35, cnt);
    check("t4_no_late_strobe", cnt, 0);

    // T6: drop enable mid-divide, then a fresh window
    feed_window(T1_RED, T1_IR);
    repeat (11) step();
    enable = 1'b0;
    count_strobes(40, cnt);
    check("t6_no_strobe_disabled", cnt, 0);
    check("t6_spo2_hold", spo2, 98);
    check("t6_ratio_hold", ratio_q8, 128);
    check("t6_overrun_clear", overrun, 0);
    enable = 1'b1;
    step();
    feed_window(T1_RED, T1_IR);
    wait_result(lat, v, e);
    check("t6_valid_seen", v, 1);
    check("t6_latency", lat, 27);
    check("t6_ratio_q8", ratio_q8, 277);
    check("t6_spo2", spo2, 83);

    // T5: second window closes during DIV -> overrun, second discarded
    feed_window(T2_RED, T2_IR);
    step();
    feed_window(T1_RED, T1_IR);
    step();
    check("t5_overrun_set", overrun, 1);
    wait_result(lat, v, e);
    check("t5_valid_seen", v, 1);
    check("t5_latency_rest", lat, 21);
    check("t5_ratio_q8", ratio_q8, 128);
    check("t5_spo2", spo2, 98);
    count_strobes(40, cnt);
    check("t5_second_discarded", cnt, 0);
    check("t5_overrun_sticky", overrun, 1);

    // Asynchronous reset in the middle of a divide
    feed_window(T1_RED, T1_IR);
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_spo2_valid", spo2_valid, 0);
    check("rstmid_spo2", spo2, 0);
    check("rstmid_ratio_q8", ratio_q8, 0);
    check("rstmid_spo2_err", spo2_err, 0);
    check("rstmid_overrun", overrun, 0);
    step();
    rst_n = 1'b1;
    count_strobes(40, cnt);
    check("rstmid_no_strobe", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
